// File: rtl/calpoc_pkg.sv
// Shared definitions for the calculator front end: button bit mapping,
// lockout state encoding and the press-priority picker.
package calpoc_pkg;

  localparam int CALPOC_NUM_BUTTONS = 6;

  localparam int BTN_1   = 0;
  localparam int BTN_0   = 1;
  localparam int BTN_OR  = 2;
  localparam int BTN_XOR = 3;
  localparam int BTN_EQ  = 4;
  localparam int BTN_CLR = 5;

  typedef enum logic {
    BCOND_IDLE    = 1'b0,
    BCOND_PRESSED = 1'b1
  } bcond_state_t;

  // One-hot grant for the winning request. OR deliberately outranks XOR,
  // so this is not a plain MSB-first priority encoder.
  function automatic logic [CALPOC_NUM_BUTTONS-1:0] calpoc_pick(
    input logic [CALPOC_NUM_BUTTONS-1:0] req
  );
    logic [CALPOC_NUM_BUTTONS-1:0] grant;
    grant = '0;
    if (req[BTN_CLR])      grant[BTN_CLR] = 1'b1;
    else if (req[BTN_EQ])  grant[BTN_EQ]  = 1'b1;
    else if (req[BTN_OR])  grant[BTN_OR]  = 1'b1;
    else if (req[BTN_XOR]) grant[BTN_XOR] = 1'b1;
    else if (req[BTN_0])   grant[BTN_0]   = 1'b1;
    else if (req[BTN_1])   grant[BTN_1]   = 1'b1;
    return grant;
  endfunction

endpackage

// File: rtl/calpoc_debounce.sv
// Single-channel synchronizer plus debouncer. The stable level only flips
// after DEBOUNCE_CYCLES consecutive edges of disagreement with the synced input.
module calpoc_debounce
  import calpoc_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_stable,
  output logic o_stable_next,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;

  logic w_synced;
  logic w_differ;
  logic w_flip;
  logic w_stable_next;

  assign w_synced      = r_sync[SYNC_STAGES-1];
  assign w_differ      = w_synced ^ r_stable;
  assign w_flip        = w_differ && (r_cnt == CNT_LAST);
  assign w_stable_next = r_stable ^ w_flip;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_stable <= w_stable_next;
      // Any agreeing cycle throws away the partial count.
      if (!w_differ || w_flip) r_cnt <= '0;
      else                     r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable      = r_stable;
  assign o_stable_next = w_stable_next;
  assign o_rise        = w_flip & ~r_stable;

endmodule

// File: rtl/calpoc_button_conditioner.sv
// Debounces the six calculator buttons and emits at most one registered
// press pulse per cycle, with a lockout so held buttons never repeat.
module calpoc_button_conditioner
  import calpoc_pkg::*;
#(
  parameter int NUM_BUTTONS     = CALPOC_NUM_BUTTONS,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_BUTTONS-1:0] ButtonRaw,
  output logic [NUM_BUTTONS-1:0] ButtonPulse,
  output logic [NUM_BUTTONS-1:0] ButtonLevel,
  output logic                   Busy
);

  logic [NUM_BUTTONS-1:0] w_level;
  logic [NUM_BUTTONS-1:0] w_level_next;
  logic [NUM_BUTTONS-1:0] w_rise;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    calpoc_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk         (CLK),
      .i_rst         (RST),
      .i_raw         (ButtonRaw[g]),
      .o_stable      (w_level[g]),
      .o_stable_next (w_level_next[g]),
      .o_rise        (w_rise[g])
    );
  end

  bcond_state_t           r_state;
  bcond_state_t           w_state_next;
  logic [NUM_BUTTONS-1:0] r_pulse;
  logic [NUM_BUTTONS-1:0] w_pulse_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= BCOND_IDLE;
      r_pulse <= '0;
    end else begin
      r_state <= w_state_next;
      r_pulse <= w_pulse_next;
    end
  end

  // Lockout: only the first press after all buttons are released gets through,
  // except Clear, which must always reach the calculator.
  always_comb begin
    w_state_next = r_state;
    w_pulse_next = '0;
    case (r_state)
      BCOND_IDLE: begin
        if (|w_rise) begin
          w_pulse_next = calpoc_pick(w_rise);
          w_state_next = BCOND_PRESSED;
        end
      end
      BCOND_PRESSED: begin
        if (w_rise[BTN_CLR]) w_pulse_next[BTN_CLR] = 1'b1;
        if (w_level_next == '0) w_state_next = BCOND_IDLE;
      end
      default: w_state_next = BCOND_IDLE;
    endcase
  end

  assign ButtonPulse = r_pulse;
  assign ButtonLevel = w_level;
  assign Busy        = (r_state == BCOND_PRESSED);

endmodule

// File: tb/tb_calpoc_button_conditioner.sv
// Self-checking bench for calpoc_button_conditioner with SYNC_STAGES=2 and
// DEBOUNCE_CYCLES=4: a raw change first sampled at edge k settles at edge k+5.
module tb_calpoc_button_conditioner;

  localparam int W = 22;  // {cycle[15:0], pulse[5:0]}

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] raw;
  logic [5:0] pulse;
  logic [5:0] level;
  logic       busy;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [5:0] press;
    logic [5:0] exp_pulse;
  } vec_t;

  vec_t vecs[8];

  calpoc_button_conditioner #(
    .NUM_BUTTONS     (6),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .ButtonRaw   (raw),
    .ButtonPulse (pulse),
    .ButtonLevel (level),
    .Busy        (busy)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver and checker tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expect_pulse(input int at_cyc, input logic [5:0] p);
    logic [15:0] t;
    t = 16'(at_cyc);
    exp_q.push_back({t, p});
  endtask

  // Drive a new raw level at a negedge; a predicted pulse shows up 6 negedges later.
  task automatic press(input logic [5:0] v, input logic [5:0] p);
    raw = v;
    if (p != 6'b0) expect_pulse(cyc + 6, p);
  endtask

  task automatic chk_outputs(input string name, input logic [5:0] exp_level, input logic exp_busy);
    chk({name, "_level"}, level, exp_level);
    chk({name, "_busy"}, {5'b0, busy}, {5'b0, exp_busy});
  endtask

  initial begin
    int c;

    vecs[0] = '{6'b000001, 6'b000001};
    vecs[1] = '{6'b000010, 6'b000010};
    vecs[2] = '{6'b001100, 6'b000100};
    vecs[3] = '{6'b011111, 6'b010000};
    vecs[4] = '{6'b111111, 6'b100000};
    vecs[5] = '{6'b001010, 6'b001000};
    vecs[6] = '{6'b101000, 6'b100000};
    vecs[7] = '{6'b000011, 6'b000010};

    raw = 6'b0;
    rst = 1'b1;

    // Scoreboard monitor: every nonzero pulse must match the queue head, value and cycle.
    fork
      begin : mon
        logic [W-1:0] e;
        forever begin
          @(negedge clk);
          if (pulse !== 6'b0) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_pulse", pulse, 6'b0);
            end else begin
              e = exp_q.pop_front();
              chk("pulse_value", pulse, e[5:0]);
              chk_int("pulse_cycle", cyc, int'(e[21:6]));
            end
          end
        end
      end
    join_none

    tick(3);
    chk("reset_pulse", pulse, 6'b0);
    chk_outputs("reset", 6'b0, 1'b0);
    rst = 1'b0;
    tick(2);

    // Clean press with exact rise/fall timing
    c = cyc;
    press(6'b000001, 6'b000001);
    tick(5);
    chk_outputs("clean_pre", 6'b0, 1'b0);
    tick(1);
    chk_outputs("clean_rise", 6'b000001, 1'b1);
    tick(14);
    press(6'b0, 6'b0);
    tick(5);
    chk_outputs("clean_prerel", 6'b000001, 1'b1);
    tick(1);
    chk_outputs("clean_rel", 6'b0, 1'b0);
    tick(6);

    // Three-cycle glitch is filtered
    raw = 6'b000010;
    tick(3);
    raw = 6'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk_outputs("glitch", 6'b0, 1'b0);
    end

    // Four-cycle pulse is the shortest accepted press
    press(6'b000010, 6'b000010);
    tick(4);
    raw = 6'b0;
    tick(12);
    chk_outputs("min_press", 6'b0, 1'b0);

    // Priority table
    for (int i = 0; i < 8; i++) begin
      press(vecs[i].press, vecs[i].exp_pulse);
      tick(10);
      chk_outputs("vec_hold", vecs[i].press, 1'b1);
      raw = 6'b0;
      tick(10);
      chk_outputs("vec_rel", 6'b0, 1'b0);
    end

    // Bounce then hold: exactly one Equals pulse
    for (int i = 0; i < 6; i++) begin
      raw = (i % 2 == 0) ? 6'b010000 : 6'b0;
      tick(1);
    end
    press(6'b010000, 6'b010000);
    tick(12);
    chk_outputs("bounce_hold", 6'b010000, 1'b1);
    raw = 6'b0;
    tick(10);

    // Simultaneous OR+XOR, release XOR first
    press(6'b001100, 6'b000100);
    tick(10);
    chk_outputs("simul_both", 6'b001100, 1'b1);
    raw = 6'b000100;
    tick(10);
    chk_outputs("simul_one", 6'b000100, 1'b1);
    raw = 6'b0;
    tick(5);
    chk_outputs("simul_prerel", 6'b000100, 1'b1);
    tick(1);
    chk_outputs("simul_rel", 6'b0, 1'b0);
    tick(4);

    // Clear overrides the lockout
    press(6'b000001, 6'b000001);
    tick(10);
    press(6'b100001, 6'b100000);
    tick(10);
    chk_outputs("clear_both", 6'b100001, 1'b1);
    raw = 6'b100000;
    tick(10);
    chk_outputs("clear_only", 6'b100000, 1'b1);
    raw = 6'b0;
    tick(10);
    chk_outputs("clear_rel", 6'b0, 1'b0);

    // Reset in the middle of a debounce restarts the count
    c = cyc;
    raw = 6'b000001;
    expect_pulse(c + 10, 6'b000001);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_pulse", pulse, 6'b0);
    chk_outputs("rst_mid", 6'b0, 1'b0);
    rst = 1'b0;
    tick(5);
    chk_outputs("rst_pre", 6'b0, 1'b0);
    tick(1);
    chk_outputs("rst_rise", 6'b000001, 1'b1);
    tick(5);
    raw = 6'b0;
    tick(10);
    chk_outputs("rst_rel", 6'b0, 1'b0);

    tick(10);
    chk_int("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calpoc_button_conditioner.md
Name: calpoc_button_conditioner

Overview:
Front-end stage that sits directly upstream of the calculator FSM. It takes the six raw, asynchronous, bouncing push-button inputs and does three things:
- synchronizes and debounces each button;
- arbitrates between them;
- delivers at most one single-cycle press pulse per cycle on the FSM's button inputs.

A lockout state machine stops a held button from producing repeat presses. It also stops a second button pressed while one is held from reaching the FSM. ButtonForClear is the only exception.

Parameters:
- NUM_BUTTONS, 6: number of button channels. Fixed by the bit mapping; not meant to be overridden.
- SYNC_STAGES, 2: synchronizer flop depth. Minimum 2.
- DEBOUNCE_CYCLES, 16: number of consecutive cycles a synchronized level must differ from the stable level before it is accepted. Minimum 2. Counter width is $clog2(DEBOUNCE_CYCLES).

Ports:
- CLK  in  1  system clock. Single clock domain.
- RST  in  1  synchronous, active-high reset.
- ButtonRaw  in  6  raw button levels, asynchronous to CLK, 1 = pressed. Bit mapping: [0] For1, [1] For0, [2] ForOR, [3] ForXOR, [4] ForEquals, [5] ForClear.
- ButtonPulse  out  6  one-cycle press pulses, same bit mapping. Always one-hot or zero. Feeds the FSM button inputs.
- ButtonLevel  out  6  debounced stable levels.
- Busy  out  1  high while the lockout FSM is in PRESSED.

Behaviour:
Clock and reset
- One clock, CLK. Reset RST is synchronous and active-high.
- RST clears all synchronizer flops, stable levels, counters, ButtonPulse, ButtonLevel and Busy to 0, and puts the FSM in IDLE.
- RST takes effect on the edge where it is sampled high.
- A button held through reset is treated as a new press after a full debounce from the first edge after RST deasserts.
- RST during a debounce discards the partial count.

Per-channel debounce
- Synchronizer: SYNC_STAGES flops per channel. The last stage is "synced".
- When synced equals stable, the counter is held at 0.
- When synced differs from stable, the counter increments each edge.
- On the DEBOUNCE_CYCLES-th consecutive differing edge, stable flips and the counter clears.
- Any cycle where synced equals stable again resets the counter, so a glitch shorter than DEBOUNCE_CYCLES produces no change.
- Latency: raw first sampled high at edge k → stable, and rise event, at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. Release behaves the same way.
- A rise event is a 0→1 transition of stable, computed from next-stable at the flipping edge.

Lockout FSM (states IDLE, PRESSED)
- IDLE, no rise event: ButtonPulse = 0.
- IDLE, one or more rise events on the same edge:
  - register a single pulse for the highest-priority button only;
  - priority order is Clear > Equals > OR > XOR > For0 > For1;
  - go to PRESSED.
- PRESSED:
  - ButtonPulse = 0, except that a Clear rise event registers 6'b100000 and the FSM stays in PRESSED;
  - return to IDLE on the edge where next ButtonLevel == 0.
- A rise event on the same edge as the return to IDLE cannot occur, because next ButtonLevel ≠ 0 in that case.
- Busy = (state == PRESSED), registered.
- ButtonPulse is registered and high for exactly one cycle. ButtonPulse and Busy change on the same edge.
- ButtonLevel is driven directly from the stable flops.

Decomposition:
- Shared package calpoc_pkg contains:
  - button index constants BTN_1=0, BTN_0=1, BTN_OR=2, BTN_XOR=3, BTN_EQ=4, BTN_CLR=5;
  - CALPOC_NUM_BUTTONS = 6;
  - lockout state encoding BCOND_IDLE / BCOND_PRESSED.
- One sub-module, calpoc_debounce: single-bit synchronizer, counter and stable flop.
  - Parameters SYNC_STAGES and DEBOUNCE_CYCLES.
  - Outputs stable and rise.
  - Instantiated NUM_BUTTONS times in a generate loop.
- Arbitration and the lockout FSM stay in calpoc_button_conditioner.

Test Plan:
The bench uses SYNC_STAGES=2 and DEBOUNCE_CYCLES=4, so debounce latency is k+5.
1. Clean press: ButtonRaw[0] high from edge k for 20 cycles, then low. Required response:
   - ButtonPulse = 6'b000001 for exactly one cycle after edge k+5;
   - ButtonLevel[0] and Busy rise on edge k+5;
   - after release sampled at edge r, ButtonLevel[0] and Busy fall on edge r+5, with no second pulse.
2. Glitch: ButtonRaw[1] high for 3 cycles → ButtonPulse stays 0, ButtonLevel stays 0, Busy stays 0.
3. Bounce: ButtonRaw[4] toggles 1,0,1,0,1,0, then holds 1 from edge k → exactly one pulse 6'b010000 after edge k+5.
4. Simultaneous press: ButtonRaw[2] and ButtonRaw[3] rise on the same cycle. Required response:
   - only 6'b000100 is pulsed; Busy goes high;
   - releasing [3] while [2] stays held produces no pulse and Busy stays high;
   - releasing [2] drops Busy at release+5.
5. Clear override: hold ButtonRaw[0] past its pulse, then raise ButtonRaw[5] at edge m. Required response:
   - a second pulse 6'b100000 after edge m+5;
   - no further 6'b000001 pulse;
   - Busy stays high until both buttons are released.
6. Reset mid-debounce: ButtonRaw[0] high from edge k, RST high at edge k+3 only, button still held. Required response:
   - all outputs 0 after edge k+3;
   - pulse 6'b000001 after edge k+9 (5 edges after the first post-reset edge k+4), not at k+5.
